// File: rtl/cx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cx_arb_pkg
// Description : Shared definitions for the CX request arbiter: FSM state
//               encodings, CX field widths and the default timeout status.
// Revision    : 1.0 - initial release
// ============================================================================
package cx_arb_pkg;

    // CX field widths
    localparam int c_ID_W     = 2;
    localparam int c_DATA_W   = 32;
    localparam int c_STATUS_W = 4;

    // Status reported upstream when the switch fails to answer in time
    localparam logic [c_STATUS_W-1:0] c_TO_STATUS_DEFAULT = 4'hF;

    // Arbiter FSM state encodings
    typedef logic [2:0] arb_state_t;
    localparam arb_state_t c_ST_IDLE      = 3'd0;
    localparam arb_state_t c_ST_ISSUE     = 3'd1;
    localparam arb_state_t c_ST_WAIT_RESP = 3'd2;
    localparam arb_state_t c_ST_TO_RESP   = 3'd3;
    localparam arb_state_t c_ST_DRAIN     = 3'd4;

endpackage : cx_arb_pkg
`default_nettype wire

// File: rtl/cx_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : cx_req_arbiter_if
// Description : Bundle of the upstream (requester-side, packed per requester)
//               and downstream (switch-side cx_*) handshake signals.
//               master : the arbiter's view
//               slave  : the environment's view (requesters + switch)
// Revision    : 1.0 - initial release
// ============================================================================
interface cx_req_arbiter_if
    import cx_arb_pkg::*;
#(
    parameter int N_REQ = 2
);
    // Upstream request side
    logic [N_REQ-1:0]          up_req_valid;
    logic [N_REQ-1:0]          up_req_ready;
    logic [c_ID_W*N_REQ-1:0]   up_cxu_id;
    logic [c_ID_W*N_REQ-1:0]   up_state_id;
    logic [c_DATA_W*N_REQ-1:0] up_data0;
    logic [c_DATA_W*N_REQ-1:0] up_data1;
    // Upstream response side
    logic [N_REQ-1:0]          up_resp_valid;
    logic [N_REQ-1:0]          up_resp_ready;
    logic [c_DATA_W-1:0]       up_resp_data;
    logic [c_STATUS_W-1:0]     up_resp_status;
    // Downstream (switch) request side
    logic                      dn_req_valid;
    logic                      dn_req_ready;
    logic [c_ID_W-1:0]         dn_cxu_id;
    logic [c_ID_W-1:0]         dn_state_id;
    logic [c_DATA_W-1:0]       dn_data0;
    logic [c_DATA_W-1:0]       dn_data1;
    // Downstream (switch) response side
    logic                      dn_resp_valid;
    logic                      dn_resp_ready;
    logic [c_DATA_W-1:0]       dn_resp_data;
    logic [c_STATUS_W-1:0]     dn_resp_status;

    modport master (
        input  up_req_valid, up_cxu_id, up_state_id, up_data0, up_data1,
        input  up_resp_ready,
        output up_req_ready, up_resp_valid, up_resp_data, up_resp_status,
        output dn_req_valid, dn_cxu_id, dn_state_id, dn_data0, dn_data1,
        output dn_resp_ready,
        input  dn_req_ready, dn_resp_valid, dn_resp_data, dn_resp_status
    );

    modport slave (
        output up_req_valid, up_cxu_id, up_state_id, up_data0, up_data1,
        output up_resp_ready,
        input  up_req_ready, up_resp_valid, up_resp_data, up_resp_status,
        input  dn_req_valid, dn_cxu_id, dn_state_id, dn_data0, dn_data1,
        input  dn_resp_ready,
        output dn_req_ready, dn_resp_valid, dn_resp_data, dn_resp_status
    );

endinterface : cx_req_arbiter_if
`default_nettype wire

// File: rtl/cx_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority picker. Selects the first
//               set bit of i_valid searching upward from i_ptr with wrap.
//   i_valid : request vector        i_ptr  : highest-priority index
//   o_grant : one-hot winner        o_idx  : winner index
//   o_any   : a winner exists
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire logic [N_REQ-1:0] i_valid,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N_REQ-1:0] o_grant,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_any
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (!o_any && i_valid[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDX_W'(w_pos);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/cx_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cx_req_arbiter
// Description : Shares the single CX request/response port of the CXU switch
//               among N_REQ requesters. Round-robin grant, one transaction in
//               flight, response routed to the owner, response watchdog that
//               reports TO_STATUS and then drains the late response.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : cx_req_arbiter_if.master (up_* requester side, dn_* switch side)
// Revision    : 1.0 - initial release
// ============================================================================
module cx_req_arbiter
    import cx_arb_pkg::*;
#(
    parameter int                    N_REQ     = 2,
    parameter int                    TIMEOUT   = 256,
    parameter logic [c_STATUS_W-1:0] TO_STATUS = c_TO_STATUS_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    cx_req_arbiter_if.master  bus
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N_REQ - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_MAX  = c_TMR_W'(TIMEOUT);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_TMR_W-1:0]    r_timer;
    logic [c_ID_W-1:0]     r_cxu_id;
    logic [c_ID_W-1:0]     r_state_id;
    logic [c_DATA_W-1:0]   r_data0;
    logic [c_DATA_W-1:0]   r_data1;

    logic [N_REQ-1:0]      w_grant;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_any;
    logic                  w_owner_rdy;
    logic                  w_dn_hs;
    logic                  w_timeout;
    logic [c_IDX_W-1:0]    w_owner_nxt;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_rr_pick (
        .i_valid (bus.up_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_owner_rdy = bus.up_resp_ready[r_owner];
    assign w_dn_hs     = (r_state == c_ST_WAIT_RESP) && bus.dn_resp_valid && w_owner_rdy;
    // A response arriving on the last watchdog cycle takes precedence.
    assign w_timeout   = (TIMEOUT != 0) && (r_state == c_ST_WAIT_RESP)
                         && (r_timer == c_TMR_LAST) && !bus.dn_resp_valid;
    assign w_owner_nxt = (r_owner == c_LAST_IDX) ? '0 : r_owner + 1'b1;

    // ------------------------------------------------------------ state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (w_any)              w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE:     if (bus.dn_req_ready)   w_state_nxt = c_ST_WAIT_RESP;
            c_ST_WAIT_RESP: begin
                if (w_dn_hs)                        w_state_nxt = c_ST_IDLE;
                else if (w_timeout)                 w_state_nxt = c_ST_TO_RESP;
            end
            c_ST_TO_RESP:   if (w_owner_rdy)        w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN:     if (bus.dn_resp_valid)  w_state_nxt = c_ST_IDLE;
            default:                                w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_timer    <= '0;
            r_cxu_id   <= '0;
            r_state_id <= '0;
            r_data0    <= '0;
            r_data1    <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_any) begin
                r_owner    <= w_idx;
                r_cxu_id   <= bus.up_cxu_id[c_ID_W*int'(w_idx) +: c_ID_W];
                r_state_id <= bus.up_state_id[c_ID_W*int'(w_idx) +: c_ID_W];
                r_data0    <= bus.up_data0[c_DATA_W*int'(w_idx) +: c_DATA_W];
                r_data1    <= bus.up_data1[c_DATA_W*int'(w_idx) +: c_DATA_W];
            end
            // Pointer moves past the owner once the owner has its answer
            // (real or timeout), so every holder is reached within N_REQ turns.
            if (w_dn_hs || ((r_state == c_ST_TO_RESP) && w_owner_rdy)) begin
                r_rr_ptr <= w_owner_nxt;
            end
            if ((r_state == c_ST_ISSUE) && bus.dn_req_ready) begin
                r_timer <= '0;
            end else if ((r_state == c_ST_WAIT_RESP) && !w_dn_hs && (r_timer != c_TMR_MAX)) begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        bus.up_req_ready   = '0;
        bus.up_resp_valid  = '0;
        bus.up_resp_data   = '0;
        bus.up_resp_status = '0;
        bus.dn_req_valid   = 1'b0;
        bus.dn_resp_ready  = 1'b0;
        bus.dn_cxu_id      = r_cxu_id;
        bus.dn_state_id    = r_state_id;
        bus.dn_data0       = r_data0;
        bus.dn_data1       = r_data1;
        case (r_state)
            c_ST_IDLE: begin
                // Gated by rst_n so no grant is visible while reset is held.
                if (rst_n) begin
                    bus.up_req_ready = w_grant;
                end
            end
            c_ST_ISSUE: begin
                bus.dn_req_valid = 1'b1;
            end
            c_ST_WAIT_RESP: begin
                bus.up_resp_valid[r_owner] = bus.dn_resp_valid;
                bus.up_resp_data           = bus.dn_resp_data;
                bus.up_resp_status         = bus.dn_resp_status;
                bus.dn_resp_ready          = w_owner_rdy;
            end
            c_ST_TO_RESP: begin
                bus.up_resp_valid[r_owner] = 1'b1;
                bus.up_resp_status         = TO_STATUS;
            end
            c_ST_DRAIN: begin
                bus.dn_resp_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : cx_req_arbiter
`default_nettype wire

// File: tb/tb_cx_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cx_req_arbiter
// Description : Directed self-checking bench for cx_req_arbiter
//               (N_REQ=2, TIMEOUT=8, TO_STATUS=4'hF).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cx_req_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cx_req_arbiter_if #(.N_REQ(2)) bus ();

    cx_req_arbiter #(
        .N_REQ     (2),
        .TIMEOUT   (8),
        .TO_STATUS (4'hF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        bus.up_req_valid   = '0;
        bus.up_cxu_id      = '0;
        bus.up_state_id    = '0;
        bus.up_data0       = '0;
        bus.up_data1       = '0;
        bus.up_resp_ready  = '0;
        bus.dn_req_ready   = 1'b0;
        bus.dn_resp_valid  = 1'b0;
        bus.dn_resp_data   = '0;
        bus.dn_resp_status = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.up_req_valid = 2'b11;
        tick(); tick();
        checks++;
        if (bus.up_req_ready !== 2'b00 || bus.dn_req_valid !== 1'b0 || bus.up_resp_valid !== 2'b00
            || bus.dn_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: got rdy=%b dnv=%b rv=%b dnr=%b, expected all 0",
                     bus.up_req_ready, bus.dn_req_valid, bus.up_resp_valid, bus.dn_resp_ready);
        end
        checks++;
        if (bus.up_resp_data !== 32'h0 || bus.up_resp_status !== 4'h0 || bus.dn_cxu_id !== 2'd0
            || bus.dn_state_id !== 2'd0 || bus.dn_data0 !== 32'h0 || bus.dn_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got rd=%h rs=%h id=%h d0=%h d1=%h, expected 0",
                     bus.up_resp_data, bus.up_resp_status, bus.dn_cxu_id, bus.dn_data0, bus.dn_data1);
        end
        bus.up_req_valid = 2'b00;
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.up_req_valid = 2'b01;
        bus.up_cxu_id    = 4'b0010;
        bus.up_state_id  = 4'b0001;
        bus.up_data0     = {32'h0, 32'h11};
        bus.up_data1     = {32'h0, 32'h22};
        settle();
        checks++;
        if (bus.up_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_grant: got %b expected 01", bus.up_req_ready);
        end
        tick();
        bus.up_req_valid = 2'b00;
        settle();
        checks++;
        if (bus.dn_req_valid !== 1'b1 || bus.dn_cxu_id !== 2'd2 || bus.dn_state_id !== 2'd1
            || bus.dn_data0 !== 32'h11 || bus.dn_data1 !== 32'h22 || bus.up_req_ready !== 2'b00) begin
            errors++;
            $display("FAIL single_issue: got v=%b id=%h st=%h d0=%h d1=%h rdy=%b, expected 1 2 1 11 22 00",
                     bus.dn_req_valid, bus.dn_cxu_id, bus.dn_state_id, bus.dn_data0, bus.dn_data1,
                     bus.up_req_ready);
        end
        bus.dn_req_ready = 1'b1;
        tick();
        bus.dn_req_ready   = 1'b0;
        bus.dn_resp_valid  = 1'b1;
        bus.dn_resp_data   = 32'hABCD;
        bus.dn_resp_status = 4'h0;
        bus.up_resp_ready  = 2'b01;
        settle();
        checks++;
        if (bus.dn_req_valid !== 1'b0 || bus.up_resp_valid !== 2'b01 || bus.up_resp_data !== 32'hABCD
            || bus.up_resp_status !== 4'h0 || bus.dn_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_resp: got dnv=%b rv=%b d=%h s=%h dnr=%b, expected 0 01 abcd 0 1",
                     bus.dn_req_valid, bus.up_resp_valid, bus.up_resp_data, bus.up_resp_status,
                     bus.dn_resp_ready);
        end
        tick();
        bus.dn_resp_valid = 1'b0;
        settle();
        checks++;
        if (bus.up_resp_valid !== 2'b00 || bus.dn_resp_ready !== 1'b0 || bus.dn_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got rv=%b dnr=%b dnv=%b, expected 00 0 0",
                     bus.up_resp_valid, bus.dn_resp_ready, bus.dn_req_valid);
        end
    endtask

    // Requester 1 transaction with request and response backpressure.
    task automatic test_backpressure();
        bus.up_req_valid = 2'b10;
        bus.up_cxu_id    = 4'b1100;
        bus.up_state_id  = 4'b1000;
        bus.up_data0     = {32'hA1, 32'h0};
        bus.up_data1     = {32'hB1, 32'h0};
        settle();
        checks++;
        if (bus.up_req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 10", bus.up_req_ready);
        end
        tick();
        bus.up_req_valid = 2'b00;
        bus.up_data0     = '0;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (bus.dn_req_valid !== 1'b1 || bus.dn_cxu_id !== 2'd3 || bus.dn_state_id !== 2'd2
                || bus.dn_data0 !== 32'hA1 || bus.dn_data1 !== 32'hB1) begin
                errors++;
                $display("FAIL bp_req_stable[%0d]: got v=%b id=%h st=%h d0=%h d1=%h, expected 1 3 2 a1 b1",
                         c, bus.dn_req_valid, bus.dn_cxu_id, bus.dn_state_id, bus.dn_data0, bus.dn_data1);
            end
            tick();
        end
        bus.dn_req_ready = 1'b1;
        tick();
        bus.dn_req_ready   = 1'b0;
        bus.dn_resp_valid  = 1'b1;
        bus.dn_resp_data   = 32'h777;
        bus.dn_resp_status = 4'h3;
        bus.up_resp_ready  = 2'b01;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (bus.dn_resp_ready !== 1'b0 || bus.up_resp_valid !== 2'b10 || bus.up_resp_data !== 32'h777
                || bus.up_resp_status !== 4'h3) begin
                errors++;
                $display("FAIL bp_resp_hold[%0d]: got dnr=%b rv=%b d=%h s=%h, expected 0 10 777 3",
                         c, bus.dn_resp_ready, bus.up_resp_valid, bus.up_resp_data, bus.up_resp_status);
            end
            tick();
        end
        bus.up_resp_ready = 2'b10;
        settle();
        checks++;
        if (bus.dn_resp_ready !== 1'b1 || bus.up_resp_valid !== 2'b10) begin
            errors++;
            $display("FAIL bp_resp_accept: got dnr=%b rv=%b, expected 1 10", bus.dn_resp_ready, bus.up_resp_valid);
        end
        tick();
        bus.dn_resp_valid = 1'b0;
        bus.up_resp_ready = 2'b00;
    endtask

    // Both requesters held valid; pointer starts at 0 so grants go 0,1,0,1.
    task automatic test_contention();
        bus.up_req_valid = 2'b11;
        bus.up_cxu_id    = 4'b0110;
        bus.up_data0     = {32'h33, 32'h11};
        for (int t = 0; t < 4; t++) begin
            settle();
            checks++;
            if (bus.up_req_ready !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL cont_grant[%0d]: got %b expected %b", t, bus.up_req_ready,
                         (t % 2 == 0) ? 2'b01 : 2'b10);
            end
            tick();
            settle();
            checks++;
            if (bus.up_req_ready !== 2'b00 || bus.dn_req_valid !== 1'b1
                || bus.dn_cxu_id !== ((t % 2 == 0) ? 2'd2 : 2'd1)
                || bus.dn_data0 !== ((t % 2 == 0) ? 32'h11 : 32'h33)) begin
                errors++;
                $display("FAIL cont_issue[%0d]: got rdy=%b v=%b id=%h d0=%h", t, bus.up_req_ready,
                         bus.dn_req_valid, bus.dn_cxu_id, bus.dn_data0);
            end
            bus.dn_req_ready = 1'b1;
            tick();
            bus.dn_req_ready  = 1'b0;
            bus.dn_resp_valid = 1'b1;
            bus.dn_resp_data  = 32'h100 + t;
            bus.up_resp_ready = 2'b11;
            settle();
            checks++;
            if (bus.up_req_ready !== 2'b00 || bus.up_resp_valid !== ((t % 2 == 0) ? 2'b01 : 2'b10)
                || bus.up_resp_data !== 32'h100 + t) begin
                errors++;
                $display("FAIL cont_resp[%0d]: got rdy=%b rv=%b d=%h", t, bus.up_req_ready,
                         bus.up_resp_valid, bus.up_resp_data);
            end
            tick();
            bus.dn_resp_valid = 1'b0;
            bus.up_resp_ready = 2'b00;
        end
        bus.up_req_valid = 2'b00;
        settle();
    endtask

    // Requester 0, switch never answers; late response arrives 20 cycles into the wait.
    task automatic test_timeout();
        bus.up_req_valid = 2'b01;
        tick();
        bus.up_req_valid = 2'b00;
        bus.dn_req_ready = 1'b1;
        tick();
        bus.dn_req_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            settle();
            checks++;
            if (bus.up_resp_valid !== 2'b00) begin
                errors++;
                $display("FAIL to_wait[%0d]: got rv=%b expected 00", c, bus.up_resp_valid);
            end
            tick();
        end
        settle();
        checks++;
        if (bus.up_resp_valid !== 2'b01 || bus.up_resp_status !== 4'hF || bus.up_resp_data !== 32'h0
            || bus.dn_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL to_resp: got rv=%b s=%h d=%h dnr=%b, expected 01 f 0 0",
                     bus.up_resp_valid, bus.up_resp_status, bus.up_resp_data, bus.dn_resp_ready);
        end
        tick();
        bus.up_resp_ready = 2'b01;
        settle();
        checks++;
        if (bus.up_resp_valid !== 2'b01 || bus.up_resp_status !== 4'hF) begin
            errors++;
            $display("FAIL to_resp_hold: got rv=%b s=%h, expected 01 f", bus.up_resp_valid, bus.up_resp_status);
        end
        tick();
        bus.up_resp_ready = 2'b00;
        bus.up_req_valid  = 2'b10;
        for (int c = 10; c < 20; c++) begin
            settle();
            checks++;
            if (bus.dn_resp_ready !== 1'b1 || bus.up_resp_valid !== 2'b00 || bus.up_req_ready !== 2'b00) begin
                errors++;
                $display("FAIL drain_wait[%0d]: got dnr=%b rv=%b rdy=%b, expected 1 00 00",
                         c, bus.dn_resp_ready, bus.up_resp_valid, bus.up_req_ready);
            end
            tick();
        end
        bus.dn_resp_valid = 1'b1;
        bus.dn_resp_data  = 32'h55;
        bus.up_resp_ready = 2'b11;
        settle();
        checks++;
        if (bus.dn_resp_ready !== 1'b1 || bus.up_resp_valid !== 2'b00 || bus.up_resp_data !== 32'h0) begin
            errors++;
            $display("FAIL drain_discard: got dnr=%b rv=%b d=%h, expected 1 00 0",
                     bus.dn_resp_ready, bus.up_resp_valid, bus.up_resp_data);
        end
        tick();
        bus.dn_resp_valid = 1'b0;
        bus.up_resp_ready = 2'b00;
        settle();
        checks++;
        if (bus.up_req_ready !== 2'b10 || bus.dn_resp_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_exit: got rdy=%b dnr=%b, expected 10 0", bus.up_req_ready, bus.dn_resp_ready);
        end
        bus.up_req_valid = 2'b00;
        settle();
    endtask

    // Requester 1 (pointer is 1); response arrives on the 8th wait cycle.
    task automatic test_race();
        bus.up_req_valid = 2'b10;
        tick();
        bus.up_req_valid = 2'b00;
        bus.dn_req_ready = 1'b1;
        tick();
        bus.dn_req_ready  = 1'b0;
        bus.up_resp_ready = 2'b10;
        for (int c = 0; c < 7; c++) tick();
        bus.dn_resp_valid  = 1'b1;
        bus.dn_resp_data   = 32'hBEEF;
        bus.dn_resp_status = 4'h5;
        settle();
        checks++;
        if (bus.up_resp_valid !== 2'b10 || bus.up_resp_data !== 32'hBEEF || bus.up_resp_status !== 4'h5
            || bus.dn_resp_ready !== 1'b1) begin
            errors++;
            $display("FAIL race_resp: got rv=%b d=%h s=%h dnr=%b, expected 10 beef 5 1",
                     bus.up_resp_valid, bus.up_resp_data, bus.up_resp_status, bus.dn_resp_ready);
        end
        tick();
        bus.dn_resp_valid = 1'b0;
        bus.up_resp_ready = 2'b00;
        bus.up_req_valid  = 2'b01;
        settle();
        checks++;
        if (bus.up_resp_valid !== 2'b00 || bus.dn_resp_ready !== 1'b0 || bus.up_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL race_idle: got rv=%b dnr=%b rdy=%b, expected 00 0 01",
                     bus.up_resp_valid, bus.dn_resp_ready, bus.up_req_ready);
        end
        bus.up_req_valid = 2'b00;
        settle();
    endtask

    // Pointer moved to 1 by a req0 transaction, then reset during req1's wait.
    task automatic test_reset_mid();
        bus.up_req_valid = 2'b01;
        tick();
        bus.up_req_valid = 2'b00;
        bus.dn_req_ready = 1'b1;
        tick();
        bus.dn_req_ready  = 1'b0;
        bus.dn_resp_valid = 1'b1;
        bus.dn_resp_data  = 32'h1;
        bus.up_resp_ready = 2'b01;
        tick();
        bus.dn_resp_valid = 1'b0;
        bus.up_resp_ready = 2'b00;
        bus.up_req_valid  = 2'b10;
        tick();
        bus.up_req_valid = 2'b00;
        bus.dn_req_ready = 1'b1;
        tick();
        bus.dn_req_ready  = 1'b0;
        bus.dn_resp_valid = 1'b1;
        bus.dn_resp_data  = 32'hCAFE;
        bus.dn_resp_status = 4'h2;
        bus.up_req_valid  = 2'b11;
        settle();
        checks++;
        if (bus.up_resp_valid !== 2'b10 || bus.up_resp_data !== 32'hCAFE) begin
            errors++;
            $display("FAIL rstmid_pre: got rv=%b d=%h, expected 10 cafe", bus.up_resp_valid, bus.up_resp_data);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.up_resp_valid !== 2'b00 || bus.up_resp_data !== 32'h0 || bus.up_resp_status !== 4'h0
            || bus.dn_resp_ready !== 1'b0 || bus.up_req_ready !== 2'b00 || bus.dn_req_valid !== 1'b0
            || bus.dn_cxu_id !== 2'd0 || bus.dn_data0 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: got rv=%b d=%h s=%h dnr=%b rdy=%b dnv=%b id=%h d0=%h, expected all 0",
                     bus.up_resp_valid, bus.up_resp_data, bus.up_resp_status, bus.dn_resp_ready,
                     bus.up_req_ready, bus.dn_req_valid, bus.dn_cxu_id, bus.dn_data0);
        end
        bus.dn_resp_valid = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        checks++;
        if (bus.up_req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_ptr: got %b expected 01", bus.up_req_ready);
        end
        bus.up_req_valid = 2'b00;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cx_req_arbiter
`default_nettype wire
